mb_frame_checker: RTL and testbench

MB_FRAME_CHECKER -- requirements
Module: mb_frame_checker

---
 rtl/mb_pkg.sv | 38 +++
 rtl/mb_frame_checker_if.sv | 24 ++
 rtl/mb_crc16.sv | 16 +
 rtl/mb_frame_checker.sv | 200 ++++++++++++++++++++
 tb/tb_mb_frame_checker.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mb_pkg.sv
// Shared constants, FSM state encoding and ASCII helpers for the Modbus frame checker.
package mb_pkg;

   localparam logic [15:0] MB_CRC_INIT   = 16'hFFFF;
   localparam logic [15:0] MB_CRC_POLY   = 16'hA001;
   localparam logic [7:0]  MB_BCAST_ADDR = 8'h00;

   localparam logic [7:0] MB_CH_COLON = 8'h3A;
   localparam logic [7:0] MB_CH_CR    = 8'h0D;
   localparam logic [7:0] MB_CH_LF    = 8'h0A;
   localparam logic [7:0] MB_CH_0     = 8'h30;
   localparam logic [7:0] MB_CH_9     = 8'h39;
   localparam logic [7:0] MB_CH_UA    = 8'h41;
   localparam logic [7:0] MB_CH_UF    = 8'h46;
   localparam logic [7:0] MB_CH_LA    = 8'h61;
   localparam logic [7:0] MB_CH_LF_HEX = 8'h66;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_CHECK = 2'd2,
      ST_HOLD  = 2'd3
   } mb_state_e;

   // Returns {is_hex, nibble}; is_hex is 0 for anything outside 0-9/A-F/a-f.
   function automatic logic [4:0] mb_hex_decode(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= MB_CH_0 && c <= MB_CH_9)
         r = {1'b1, 4'(c - MB_CH_0)};
      else if (c >= MB_CH_UA && c <= MB_CH_UF)
         r = {1'b1, 4'(c - 8'h37)};
      else if (c >= MB_CH_LA && c <= MB_CH_LF_HEX)
         r = {1'b1, 4'(c - 8'h57)};
      return r;
   endfunction

endpackage

// File: rtl/mb_frame_checker_if.sv
// Frame-level signals between the UART deframer / frame consumer and the checker.
interface mb_frame_checker_if;

   // rx_valid_i qualifies rx_data_i for exactly one cycle (no backpressure);
   // frm_valid_o holds a frame until frm_ack_i is seen while frm_valid_o is high.
   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic       frame_start_i;
   logic       frame_end_i;
   logic       frm_valid_o;
   logic [8:0] frm_len_o;
   logic       frm_ack_i;

   modport master (
      output rx_data_i, rx_valid_i, frame_start_i, frame_end_i, frm_ack_i,
      input  frm_valid_o, frm_len_o
   );

   modport slave (
      input  rx_data_i, rx_valid_i, frame_start_i, frame_end_i, frm_ack_i,
      output frm_valid_o, frm_len_o
   );

endinterface

// File: rtl/mb_crc16.sv
// One combinational byte step of the reflected Modbus CRC-16.
module mb_crc16
   import mb_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ {8'h00, data_in};
      for (int i = 0; i < 8; i++)
         crc_out = crc_out[0] ? ((crc_out >> 1) ^ MB_CRC_POLY) : (crc_out >> 1);
   end

endmodule

// File: rtl/mb_frame_checker.sv
// Modbus RTU/ASCII frame checker: buffers one frame, checks CRC/LRC/format/address, holds it until ack.
// ASCII decoding and LRC are built only when MB_FRAME_ASCII_EN is defined.
module mb_frame_checker
   import mb_pkg::*;
#(
   parameter int MAX_LEN = 256,
   parameter int AW      = 8
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ascii_en,
   input  logic [7:0]    own_addr,
   input  logic [7:0]    rx_data_i,
   input  logic          rx_valid_i,
   input  logic          frame_start_i,
   input  logic          frame_end_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [7:0]    rd_data_o,
   output logic          frm_valid_o,
   output logic [8:0]    frm_len_o,
   input  logic          frm_ack_i,
   output logic          err_crc_o,
   output logic          err_lrc_o,
   output logic          err_fmt_o,
   output logic          err_ovf_o,
   output logic          drop_busy_o,
   output mb_state_e     dbg_state
);

   localparam logic [8:0] LEN_MAX = 9'(MAX_LEN);

   mb_state_e   state, state_nxt;
   logic [8:0]  count, b_count, n_count;
   logic [15:0] crc, b_crc, n_crc, crc_step;
   logic        ovf, n_ovf;
   logic [7:0]  addr_byte, n_addr, st_byte;
   logic        restart, in_frame, take, store, wr_en;
   logic        is_ascii, fmt_err, lrc_bad;
   logic        e_crc, e_lrc, e_fmt, e_ovf, drop_nxt, valid_nxt;
   logic [8:0]  len_nxt;
   logic [7:0]  mem [2**AW];

   assign dbg_state = state;

   mb_crc16 u_crc (.crc_in(b_crc), .data_in(st_byte), .crc_out(crc_step));

`ifdef MB_FRAME_ASCII_EN
   logic       mode, b_mode, fmt, n_fmt, half, n_half;
   logic [3:0] hi_nib, n_hi;
   logic [7:0] lrc, n_lrc;
   logic [4:0] hex;
   assign is_ascii = mode;
   assign fmt_err  = fmt | half;
   assign lrc_bad  = (count < 9'd3) || (lrc != 8'h00);
`else
   logic unused_ascii;
   assign unused_ascii = ascii_en;
   assign is_ascii = 1'b0;
   assign fmt_err  = 1'b0;
   assign lrc_bad  = 1'b0;
`endif

   // Datapath: a start (re)initialises the accumulators before the same-cycle byte is folded in.
   always_comb begin
      restart  = frame_start_i && (state == ST_IDLE || state == ST_RECV);
      in_frame = restart || (state == ST_RECV);
      take     = in_frame && rx_valid_i;
      b_count  = restart ? 9'd0 : count;
      b_crc    = restart ? MB_CRC_INIT : crc;
      n_count  = b_count;
      n_crc    = b_crc;
      n_ovf    = restart ? 1'b0 : ovf;
      n_addr   = addr_byte;
      st_byte  = rx_data_i;
      store    = take;
`ifdef MB_FRAME_ASCII_EN
      b_mode = restart ? ascii_en : mode;
      n_fmt  = restart ? 1'b0 : fmt;
      n_half = restart ? 1'b0 : half;
      n_hi   = hi_nib;
      n_lrc  = restart ? 8'h00 : lrc;
      hex    = mb_hex_decode(rx_data_i);
      if (take && b_mode) begin
         store = 1'b0;
         if (hex[4]) begin
            if (n_half) begin
               st_byte = {hi_nib, hex[3:0]};
               store   = 1'b1;
               n_half  = 1'b0;
               n_lrc   = n_lrc + st_byte;
            end else begin
               n_hi   = hex[3:0];
               n_half = 1'b1;
            end
         end else if (rx_data_i != MB_CH_COLON && rx_data_i != MB_CH_CR &&
                      rx_data_i != MB_CH_LF) begin
            n_fmt = 1'b1;
         end
      end
`endif
      wr_en = store && (b_count != LEN_MAX);
      if (wr_en) begin
         n_count = b_count + 9'd1;
         n_crc   = crc_step;
         if (b_count == 9'd0)
            n_addr = st_byte;
      end else if (store) begin
         n_ovf = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      len_nxt   = frm_len_o;
      e_crc     = 1'b0;
      e_lrc     = 1'b0;
      e_fmt     = 1'b0;
      e_ovf     = 1'b0;
      drop_nxt  = 1'b0;
      unique case (state)
         ST_IDLE:  if (frame_start_i) state_nxt = frame_end_i ? ST_CHECK : ST_RECV;
         ST_RECV:  if (frame_end_i) state_nxt = ST_CHECK;
         ST_CHECK: begin
            state_nxt = ST_IDLE;
            if (ovf)
               e_ovf = 1'b1;
            else if (fmt_err)
               e_fmt = 1'b1;
            else if (!is_ascii && (count < 9'd4 || crc != 16'h0000))
               e_crc = 1'b1;
            else if (is_ascii && lrc_bad)
               e_lrc = 1'b1;
            else if (addr_byte == own_addr || addr_byte == MB_BCAST_ADDR) begin
               state_nxt = ST_HOLD;
               len_nxt   = is_ascii ? (count - 9'd1) : (count - 9'd2);
            end
         end
         ST_HOLD: begin
            drop_nxt = frame_start_i;
            if (frm_ack_i && frm_valid_o) state_nxt = ST_IDLE;
         end
      endcase
      valid_nxt = (state == ST_HOLD) && !(frm_ack_i && frm_valid_o);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         count       <= 9'd0;
         crc         <= MB_CRC_INIT;
         ovf         <= 1'b0;
         addr_byte   <= 8'h00;
         frm_valid_o <= 1'b0;
         frm_len_o   <= 9'd0;
         err_crc_o   <= 1'b0;
         err_lrc_o   <= 1'b0;
         err_fmt_o   <= 1'b0;
         err_ovf_o   <= 1'b0;
         drop_busy_o <= 1'b0;
         rd_data_o   <= 8'h00;
`ifdef MB_FRAME_ASCII_EN
         mode   <= 1'b0;
         fmt    <= 1'b0;
         half   <= 1'b0;
         hi_nib <= 4'h0;
         lrc    <= 8'h00;
`endif
      end else begin
         state <= state_nxt;
         if (in_frame) begin
            count     <= n_count;
            crc       <= n_crc;
            ovf       <= n_ovf;
            addr_byte <= n_addr;
`ifdef MB_FRAME_ASCII_EN
            mode   <= b_mode;
            fmt    <= n_fmt;
            half   <= n_half;
            hi_nib <= n_hi;
            lrc    <= n_lrc;
`endif
         end
         frm_valid_o <= valid_nxt;
         frm_len_o   <= len_nxt;
         err_crc_o   <= e_crc;
         err_lrc_o   <= e_lrc;
         err_fmt_o   <= e_fmt;
         err_ovf_o   <= e_ovf;
         drop_busy_o <= drop_nxt;
         rd_data_o   <= mem[rd_addr_i];
      end
   end

   // Buffer has no reset; it is only written while a frame is being received.
   always_ff @(posedge clk) begin
      if (wr_en) mem[b_count[AW-1:0]] <= st_byte;
   end

endmodule

// File: tb/tb_mb_frame_checker.sv
// Directed and randomized bench for mb_frame_checker against a frame-level reference model.
module tb_mb_frame_checker;
   import mb_pkg::*;

   localparam int MAX_LEN = 32;
   localparam int AW      = 5;
   localparam int K_OK = 0, K_SILENT = 1, K_CRC = 2, K_LRC = 3, K_FMT = 4, K_OVF = 5;
`ifdef MB_FRAME_ASCII_EN
   localparam bit ASCII_BUILD = 1'b1;
`else
   localparam bit ASCII_BUILD = 1'b0;
`endif

   typedef logic [7:0] bq_t [$];

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          ascii_en = 1'b0;
   logic [7:0]    own_addr = 8'h01;
   logic [AW-1:0] rd_addr  = '0;
   logic [7:0]    rd_data;
   logic          err_crc, err_lrc, err_fmt, err_ovf, drop_busy;
   mb_state_e     dbg_state;

   mb_frame_checker_if bus();

   mb_frame_checker #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .ascii_en(ascii_en), .own_addr(own_addr),
      .rx_data_i(bus.rx_data_i), .rx_valid_i(bus.rx_valid_i),
      .frame_start_i(bus.frame_start_i), .frame_end_i(bus.frame_end_i),
      .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .frm_valid_o(bus.frm_valid_o), .frm_len_o(bus.frm_len_o), .frm_ack_i(bus.frm_ack_i),
      .err_crc_o(err_crc), .err_lrc_o(err_lrc), .err_fmt_o(err_fmt), .err_ovf_o(err_ovf),
      .drop_busy_o(drop_busy), .dbg_state(dbg_state)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int end_cyc = 0;
   int n_crc = 0, n_lrc = 0, n_fmt = 0, n_ovf = 0, n_drop = 0, n_rise = 0, last_rise = 0;
   logic prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: cumulative pulse counts and rise time of frm_valid_o.
   always @(negedge clk) begin
      n_crc  += err_crc   ? 1 : 0;
      n_lrc  += err_lrc   ? 1 : 0;
      n_fmt  += err_fmt   ? 1 : 0;
      n_ovf  += err_ovf   ? 1 : 0;
      n_drop += drop_busy ? 1 : 0;
      if (bus.frm_valid_o && !prev_v) begin
         n_rise++;
         last_rise = cyc;
      end
      prev_v = bus.frm_valid_o;
   end

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] crc16(input bq_t q);
      logic [15:0] c = 16'hFFFF;
      foreach (q[i]) begin
         c = c ^ {8'h00, q[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   function automatic int hex_val(input logic [7:0] ch);
      if (ch >= "0" && ch <= "9") return int'(ch) - 48;
      if (ch >= "A" && ch <= "F") return int'(ch) - 55;
      if (ch >= "a" && ch <= "f") return int'(ch) - 87;
      return -1;
   endfunction

   function automatic logic [7:0] hex_ch(input int n, input bit lower);
      if (n < 10) return 8'(48 + n);
      return lower ? 8'(87 + n) : 8'(55 + n);
   endfunction

   function automatic bq_t str2q(input string s);
      bq_t q = {};
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic bq_t to_ascii(input bq_t raw);
      bq_t q = {8'h3A};
      foreach (raw[i]) begin
         q.push_back(hex_ch(int'(raw[i][7:4]), $urandom_range(0, 1) == 1));
         q.push_back(hex_ch(int'(raw[i][3:0]), $urandom_range(0, 1) == 1));
      end
      q.push_back(8'h0D);
      q.push_back(8'h0A);
      return q;
   endfunction

   // Reference model: what the frame should produce, from the frame rules alone.
   task automatic model(input bq_t q, input bit mode_in, input logic [7:0] own,
                        output int kind, output int len, output bq_t dec);
      bit mode = mode_in && ASCII_BUILD;
      bit fmt = 1'b0;
      int nibs[$];
      int sum = 0;
      dec = {};
      len = 0;
      if (!mode) dec = q;
      else begin
         foreach (q[i]) begin
            if (q[i] == 8'h3A || q[i] == 8'h0D || q[i] == 8'h0A) continue;
            if (hex_val(q[i]) < 0) fmt = 1'b1;
            else nibs.push_back(hex_val(q[i]));
         end
         for (int i = 0; i + 1 < nibs.size(); i += 2) dec.push_back(8'(nibs[i] * 16 + nibs[i+1]));
         if (nibs.size() % 2 == 1) fmt = 1'b1;
      end
      foreach (dec[i]) sum += int'(dec[i]);
      if (dec.size() > MAX_LEN) kind = K_OVF;
      else if (fmt) kind = K_FMT;
      else if (!mode && (dec.size() < 4 || crc16(dec) != 16'h0000)) kind = K_CRC;
      else if (mode && (dec.size() < 3 || (sum % 256) != 0)) kind = K_LRC;
      else if (dec[0] == own || dec[0] == 8'h00) begin
         kind = K_OK;
         len = dec.size() - (mode ? 1 : 2);
      end else kind = K_SILENT;
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_frame(input bq_t q, input bit mode, input bit with_end);
      int idx = 0;
      bit ended = 1'b0;
      @(posedge clk); #1;
      ascii_en = mode;
      bus.frame_start_i = 1'b1;
      if (q.size() > 1 && $urandom_range(0, 1) == 1) begin
         bus.rx_valid_i = 1'b1;
         bus.rx_data_i  = q[0];
         idx = 1;
      end
      @(posedge clk); #1;
      bus.frame_start_i = 1'b0;
      bus.rx_valid_i    = 1'b0;
      ascii_en          = ($urandom_range(0, 1) == 1);
      while (idx < q.size()) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         bus.rx_valid_i = 1'b1;
         bus.rx_data_i  = q[idx];
         if (with_end && idx == q.size() - 1 && $urandom_range(0, 1) == 1) begin
            bus.frame_end_i = 1'b1;
            end_cyc = cyc;
            ended = 1'b1;
         end
         @(posedge clk); #1;
         bus.rx_valid_i  = 1'b0;
         bus.frame_end_i = 1'b0;
         idx++;
      end
      if (with_end && !ended) begin
         bus.frame_end_i = 1'b1;
         end_cyc = cyc;
         @(posedge clk); #1;
         bus.frame_end_i = 1'b0;
      end
   endtask

   task automatic read_byte(input int a, output logic [7:0] d);
      @(posedge clk); #1;
      rd_addr = AW'(a);
      @(posedge clk);
      @(negedge clk);
      d = rd_data;
   endtask

   task automatic ack_frame(input string tag);
      @(posedge clk); #1;
      bus.frm_ack_i = 1'b1;
      @(posedge clk); #1;
      bus.frm_ack_i = 1'b0;
      @(negedge clk);
      chk({tag, "_valid_after_ack"}, int'(bus.frm_valid_o), 0);
      chk({tag, "_state_after_ack"}, int'(dbg_state), int'(ST_IDLE));
   endtask

   task automatic check_frame(input string tag, input bq_t q, input bit mode, input bit do_ack,
                              output bq_t dec, output int kind);
      int len, c0, l0, f0, o0, r0, ec;
      logic [7:0] d;
      c0 = n_crc; l0 = n_lrc; f0 = n_fmt; o0 = n_ovf; r0 = n_rise;
      model(q, mode, own_addr, kind, len, dec);
      send_frame(q, mode, 1'b1);
      ec = end_cyc;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk({tag, "_crc_pulses"}, n_crc - c0, int'(kind == K_CRC));
      chk({tag, "_lrc_pulses"}, n_lrc - l0, int'(kind == K_LRC));
      chk({tag, "_fmt_pulses"}, n_fmt - f0, int'(kind == K_FMT));
      chk({tag, "_ovf_pulses"}, n_ovf - o0, int'(kind == K_OVF));
      chk({tag, "_valid"}, int'(bus.frm_valid_o), int'(kind == K_OK));
      chk({tag, "_rises"}, n_rise - r0, int'(kind == K_OK));
      if (kind == K_OK) begin
         chk({tag, "_latency"}, last_rise, ec + 3);
         chk({tag, "_len"}, int'(bus.frm_len_o), len);
         foreach (dec[i]) begin
            read_byte(i, d);
            chk($sformatf("%s_rd%0d", tag, i), int'(d), int'(dec[i]));
         end
         if (do_ack) ack_frame(tag);
      end
   endtask

   task automatic send_partial(input bq_t q);
      @(posedge clk); #1;
      ascii_en = 1'b0;
      bus.frame_start_i = 1'b1;
      @(posedge clk); #1;
      bus.frame_start_i = 1'b0;
      foreach (q[i]) begin
         bus.rx_valid_i = 1'b1;
         bus.rx_data_i  = q[i];
         @(posedge clk); #1;
         bus.rx_valid_i = 1'b0;
      end
   endtask

   function automatic bq_t with_crc(input bq_t q);
      logic [15:0] c = crc16(q);
      bq_t r = q;
      r.push_back(c[7:0]);
      r.push_back(c[15:8]);
      return r;
   endfunction

   // ---------------- directed + random sequence ----------------
   initial begin
      bq_t f, dec, dec1, raw;
      int kind, k1, d0, e0, gap;
      logic [7:0] d;
      int sum;
      bit mode;

      bus.rx_data_i = 8'h00; bus.rx_valid_i = 1'b0; bus.frame_start_i = 1'b0;
      bus.frame_end_i = 1'b0; bus.frm_ack_i = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", int'(bus.frm_valid_o), 0);
      chk("rst_len", int'(bus.frm_len_o), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_err_crc", int'(err_crc), 0);
      chk("rst_err_lrc", int'(err_lrc), 0);
      chk("rst_err_fmt", int'(err_fmt), 0);
      chk("rst_err_ovf", int'(err_ovf), 0);
      chk("rst_drop", int'(drop_busy), 0);
      chk("rst_state", int'(dbg_state), int'(ST_IDLE));
      @(posedge clk); #1;
      rst_n = 1'b1;

      own_addr = 8'h01;
      f = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
      check_frame("rtu_good", f, 1'b0, 1'b1, dec, kind);
      f[7] = 8'hCC;
      check_frame("rtu_badcrc", f, 1'b0, 1'b1, dec, kind);

      f = str2q(":010300000001FB\r\n");
      check_frame("ascii_good", f, 1'b1, 1'b1, dec, kind);
      f = str2q(":010300000001FC\r\n");
      check_frame("ascii_badlrc", f, 1'b1, 1'b1, dec, kind);
      f = str2q(":0103000000010G\r\n");
      check_frame("ascii_badchar", f, 1'b1, 1'b1, dec, kind);

      f = with_crc('{8'h05, 8'h03, 8'h00, 8'h01});
      check_frame("addr_other", f, 1'b0, 1'b1, dec, kind);
      f = with_crc('{8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03});
      check_frame("addr_bcast", f, 1'b0, 1'b1, dec, kind);

      f = {};
      for (int i = 0; i <= MAX_LEN; i++) f.push_back(8'($urandom_range(0, 255)));
      f[0] = own_addr;
      check_frame("overflow", f, 1'b0, 1'b1, dec, kind);
      f = with_crc('{8'h01, 8'h10, 8'h22, 8'h33});
      check_frame("after_ovf", f, 1'b0, 1'b1, dec, kind);

      // Frame held while a second one arrives.
      f = with_crc('{8'h01, 8'h04, 8'hA5, 8'h5A, 8'h77});
      check_frame("hold_first", f, 1'b0, 1'b0, dec1, k1);
      d0 = n_drop;
      e0 = n_crc + n_lrc + n_fmt + n_ovf;
      send_frame(with_crc('{8'h01, 8'h99, 8'h98, 8'h97, 8'h96, 8'h95}), 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("hold_drop_pulses", n_drop - d0, 1);
      chk("hold_err_pulses", n_crc + n_lrc + n_fmt + n_ovf - e0, 0);
      chk("hold_valid_kept", int'(bus.frm_valid_o), int'(k1 == K_OK));
      chk("hold_len_kept", int'(bus.frm_len_o), dec1.size() - 2);
      foreach (dec1[i]) begin
         read_byte(i, d);
         chk($sformatf("hold_rd%0d", i), int'(d), int'(dec1[i]));
      end
      ack_frame("hold");

      // Stray bytes and an ack in IDLE, then a restart part-way through a frame.
      @(posedge clk); #1;
      bus.frm_ack_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.rx_valid_i = 1'b1;
         bus.rx_data_i  = 8'(8'hE0 + i);
         @(posedge clk); #1;
      end
      bus.rx_valid_i = 1'b0;
      send_partial('{8'h01, 8'h02, 8'h03});
      bus.frm_ack_i = 1'b0;
      e0 = n_crc + n_lrc + n_fmt + n_ovf;
      f = with_crc('{8'h01, 8'h03, 8'h02, 8'h00, 8'h04});
      check_frame("restart", f, 1'b0, 1'b1, dec, kind);
      chk("restart_no_extra_err", n_crc + n_lrc + n_fmt + n_ovf - e0, 0);

      // Reset in the middle of a frame.
      send_partial('{8'h01, 8'h03, 8'h00, 8'h00, 8'h00});
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_state", int'(dbg_state), int'(ST_IDLE));
      chk("midrst_valid", int'(bus.frm_valid_o), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      f = with_crc('{8'h01, 8'h06, 8'h00, 8'h02, 8'h12, 8'h34});
      check_frame("after_rst", f, 1'b0, 1'b1, dec, kind);

      for (int t = 0; t < 24; t++) begin
         own_addr = 8'($urandom_range(1, 3));
         mode = ($urandom_range(0, 1) == 1);
         raw = {};
         gap = $urandom_range(0, 2);
         raw.push_back(gap == 0 ? own_addr : (gap == 1 ? 8'h00 : 8'($urandom_range(0, 255))));
         repeat ($urandom_range(0, MAX_LEN)) raw.push_back(8'($urandom_range(0, 255)));
         if (mode && ASCII_BUILD) begin
            sum = 0;
            foreach (raw[i]) sum += int'(raw[i]);
            raw.push_back($urandom_range(0, 9) < 8 ? 8'((256 - (sum % 256)) % 256) : 8'($urandom_range(0, 255)));
            f = to_ascii(raw);
            gap = $urandom_range(0, 9);
            if (gap == 0) f.insert($urandom_range(1, f.size() - 3), 8'h47);
            else if (gap == 1) f.delete($urandom_range(1, f.size() - 3));
         end else begin
            f = ($urandom_range(0, 9) < 8) ? with_crc(raw) : raw;
            if ($urandom_range(0, 9) == 0) f[0] = f[0] ^ 8'h80;
         end
         check_frame($sformatf("rand%0d", t), f, mode, 1'b1, dec, kind);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
